// File: rtl/seq_divider.sv
// Sequential 8-bit restoring divider: a SHIFT/SUB pair per quotient bit, result held in DONE until Run drops.
// Define SIGNED_DIV_EN for two's-complement operands (adds the FIX state and sign bits).
module seq_divider (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Load,
  input  logic [7:0] S,
  output logic [7:0] Quot,
  output logic [7:0] Rem,
  output logic       Done,
  output logic       Busy,
  output logic       DivByZero
);

  // state | meaning
  // IDLE  | waiting for Run; Load writes the divisor
  // SHIFT | shift {A,Q} left one bit
  // SUB   | trial subtract; keep the difference only if non-negative
  // FIX   | apply quotient/remainder signs (signed build only)
  // DONE  | result held until Run is released
`ifdef SIGNED_DIV_EN
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_SUB, S_FIX, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_SUB, S_DONE} state_t;
`endif

  state_t     state_q, state_d;
  logic [7:0] d_q, d_d;
  logic [8:0] a_q, a_d;
  logic [7:0] q_q, q_d;
  logic [2:0] cnt_q, cnt_d;
  logic       dbz_q, dbz_d;
  logic [7:0] d_mag, s_mag;
  logic [8:0] diff;
`ifdef SIGNED_DIV_EN
  logic       sq_q, sq_d, sr_q, sr_d;

  // |-128| comes out as 8'h80, which is exactly 128 read as unsigned
  assign d_mag = d_q[7] ? -d_q : d_q;
  assign s_mag = S[7] ? -S : S;
`else
  assign d_mag = d_q;
  assign s_mag = S;
`endif
  assign diff = a_q - {1'b0, d_mag};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      a_q     <= a_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
      sq_q    <= sq_d;
      sr_q    <= sr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    a_d     = a_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
    sq_d    = sq_q;
    sr_d    = sr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Run) begin
          if (d_q == 8'd0) begin
            q_d     = 8'hFF;
            a_d     = {1'b0, S};
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            q_d     = s_mag;
            a_d     = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
`ifdef SIGNED_DIV_EN
            sq_d    = S[7] ^ d_q[7];
            sr_d    = S[7];
`endif
            state_d = S_SHIFT;
          end
        end else if (Load) begin
          d_d = S;
        end
      end
      S_SHIFT: begin
        {a_d, q_d} = {a_q, q_q} << 1;
        state_d    = S_SUB;
      end
      S_SUB: begin
        if (!diff[8]) begin
          a_d    = diff;
          q_d[0] = 1'b1;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
`ifdef SIGNED_DIV_EN
          state_d = S_FIX;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_SHIFT;
        end
      end
`ifdef SIGNED_DIV_EN
      S_FIX: begin
        q_d     = sq_q ? -q_q : q_q;
        a_d     = {1'b0, (sr_q ? -a_q[7:0] : a_q[7:0])};
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        if (!Run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Quot      = q_q;
  assign Rem       = a_q[7:0];
  assign Done      = (state_q == S_DONE);
`ifdef SIGNED_DIV_EN
  assign Busy      = (state_q == S_SHIFT) || (state_q == S_SUB) || (state_q == S_FIX);
`else
  assign Busy      = (state_q == S_SHIFT) || (state_q == S_SUB);
`endif
  assign DivByZero = dbz_q;

endmodule
